// File: rtl/template_list_pkg.sv
// -----------------------------------------------------------------------------
// template_list_pkg
// Shared definitions for the template/word list receiver:
//   - state_t        : receiver FSM states
//   - msb_of         : floor(log2(x)), 0 for x<=1 (index of the top set bit)
//   - range_info_msb : MSB of one stored RANGE_INFO record for a word length
//   - range_bad_mask : din bits that must be zero in a range byte
//   - entry_width    : width of one output FIFO entry
// -----------------------------------------------------------------------------
package template_list_pkg;

  typedef enum logic [2:0] {
    WR_WORD       = 3'd0,
    WR_RANGE_INFO = 3'd1,
    PUSH          = 3'd2,
    PUSH_LIST_END = 3'd3,
    DISCARD       = 3'd4
  } state_t;

  function automatic int msb_of(input int x);
    int r;
    r = 0;
    for (int v = x; v > 1; v = v >> 1) r = r + 1;
    return r;
  endfunction

  // A record holds a char position (0..WORD_MAX_LEN-1) plus a flag bit on top.
  function automatic int range_info_msb(input int word_max_len);
    return 1 + msb_of(word_max_len - 1);
  endfunction

  // Bits din[6:rmsb] carry no record information; they must be zero.
  function automatic logic [7:0] range_bad_mask(input int rmsb);
    logic [7:0] m;
    m = 8'h00;
    for (int b = 0; b < 7; b++) begin
      if (b >= rmsb) m[b] = 1'b1;
    end
    return m;
  endfunction

  // Entry layout, MSB first: {chars, word_len, range_info, word_id, word_list_end}
  function automatic int entry_width(input int char_bits, input int word_max_len,
                                     input int ranges_max, input int word_id_bits);
    return word_max_len * char_bits + msb_of(word_max_len) + 1 +
           ranges_max * (range_info_msb(word_max_len) + 1) + word_id_bits + 1;
  endfunction

endpackage

// File: rtl/template_list_fifo.sv
// -----------------------------------------------------------------------------
// template_list_fifo
// Synchronous show-ahead FIFO, DEPTH x WIDTH. The head entry is presented on
// o_rd_data whenever the FIFO is non-empty (zero when empty).
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset (flushes the FIFO)
//   i_wr_en     write i_wr_data; ignored while full (even if reading)
//   i_rd_en     pop head; ignored while empty
//   o_rd_data   head entry
//   o_count     number of stored entries
//   o_full      count == DEPTH
//   o_empty     count == 0
// -----------------------------------------------------------------------------
module template_list_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = i_wr_en && (r_count != FULL_COUNT);
  assign w_do_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge CLK) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory is not reset; gating keeps the outputs at zero when nothing is stored.
  assign o_rd_data = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);

endmodule

// File: rtl/template_list_v2.sv
// -----------------------------------------------------------------------------
// template_list_v2
// Receives word-list / template-list packets byte by byte, assembles words
// (plus RANGE_INFO records for template lists) and queues them in a show-ahead
// output FIFO together with word length and word index. Every packet ends with
// a dummy entry flagged word_list_end. Malformed words are dropped and the rest
// of their packet is discarded.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   din, wr_en, full    input byte stream
//   inpkt_end           accepted byte is the last of the packet
//   is_template_list    packet type, stable over the packet
//   dout, word_len, range_info, word_id, word_list_end   head entry fields
//   rd_en, empty        output FIFO pop / empty
//   err_template        sticky format error
//   err_word_list_count sticky word_id overflow
//   o_dbg_state         current FSM state
//   o_dbg_fifo_count    output FIFO occupancy
//
// Handshakes: an input byte transfers on a rising edge where wr_en=1 and
// full=0; an output entry is consumed on a rising edge where rd_en=1 and
// empty=0. Both sides ignore their strobe otherwise, and presented data stays
// stable until it is transferred.
// -----------------------------------------------------------------------------
module template_list_v2
  import template_list_pkg::*;
#(
  parameter int CHAR_BITS    = 8,
  parameter int WORD_MAX_LEN = 8,
  parameter int RANGES_MAX   = 8,
  parameter int OUT_DEPTH    = 4,
  parameter int WORD_ID_BITS = 16
) (
  input  logic                                                   CLK,
  input  logic                                                   RST_N,
  input  logic [7:0]                                             din,
  input  logic                                                   wr_en,
  output logic                                                   full,
  input  logic                                                   inpkt_end,
  input  logic                                                   is_template_list,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0]                      dout,
  output logic [msb_of(WORD_MAX_LEN):0]                          word_len,
  output logic [RANGES_MAX*(range_info_msb(WORD_MAX_LEN)+1)-1:0] range_info,
  output logic [WORD_ID_BITS-1:0]                                word_id,
  output logic                                                   word_list_end,
  input  logic                                                   rd_en,
  output logic                                                   empty,
  output logic                                                   err_template,
  output logic                                                   err_word_list_count,
  output logic [2:0]                                             o_dbg_state,
  output logic [$clog2(OUT_DEPTH):0]                             o_dbg_fifo_count
);

  localparam int RMSB    = range_info_msb(WORD_MAX_LEN);
  localparam int RW      = RMSB + 1;
  localparam int LEN_W   = msb_of(WORD_MAX_LEN) + 1;
  localparam int RC_W    = msb_of(RANGES_MAX) + 1;
  localparam int DATA_W  = WORD_MAX_LEN * CHAR_BITS;
  localparam int RANGE_W = RANGES_MAX * RW;
  localparam int ENTRY_W = entry_width(CHAR_BITS, WORD_MAX_LEN, RANGES_MAX, WORD_ID_BITS);
  localparam logic [7:0] BAD_MASK = range_bad_mask(RMSB);

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_W-1:0]       r_chars;
  logic [LEN_W-1:0]        r_char_count;
  logic [RANGE_W-1:0]      r_ranges;
  logic [RC_W-1:0]         r_range_count;
  logic                    r_last;
  logic [WORD_ID_BITS-1:0] r_word_id;
  logic                    r_err_template;
  logic                    r_err_word_list_count;

  logic                    w_accept;
  logic                    w_byte_zero;
  logic                    w_word_ends;
  logic                    w_range_ends;
  logic                    w_range_bad;
  logic                    w_store_char;
  logic                    w_store_range;
  logic                    w_set_last;
  logic                    w_fmt_err;
  logic                    w_push_word;
  logic                    w_push_end;
  logic                    w_fifo_full;
  logic [ENTRY_W-1:0]      w_wr_data;
  logic [ENTRY_W-1:0]      w_rd_data;

  assign full        = (r_state == PUSH) || (r_state == PUSH_LIST_END);
  assign w_accept    = wr_en && !full;
  assign w_byte_zero = (din == 8'd0);
  // A nonzero byte landing at the last char slot also closes the word.
  assign w_word_ends  = w_byte_zero || (int'(r_char_count) == WORD_MAX_LEN - 1);
  assign w_range_ends = w_byte_zero || (int'(r_range_count) == RANGES_MAX - 1);
  assign w_range_bad  = |(din & BAD_MASK);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= WR_WORD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_store_char  = 1'b0;
    w_store_range = 1'b0;
    w_set_last    = 1'b0;
    w_fmt_err     = 1'b0;
    w_push_word   = 1'b0;
    w_push_end    = 1'b0;
    case (r_state)
      WR_WORD: begin
        if (w_accept) begin
          // Word-phase errors are always caused by inpkt_end, so the packet
          // is already over: go straight to the end-of-list entry.
          if (inpkt_end && (is_template_list || !w_word_ends)) begin
            w_fmt_err = 1'b1;
            w_next    = PUSH_LIST_END;
          end else begin
            w_store_char = !w_byte_zero;
            if (w_word_ends) begin
              w_next     = is_template_list ? WR_RANGE_INFO : PUSH;
              w_set_last = inpkt_end;
            end
          end
        end
      end
      WR_RANGE_INFO: begin
        if (w_accept) begin
          if (w_range_bad || (inpkt_end && !w_range_ends)) begin
            w_fmt_err = 1'b1;
            w_next    = inpkt_end ? PUSH_LIST_END : DISCARD;
          end else begin
            w_store_range = !w_byte_zero;
            if (w_range_ends) begin
              w_next     = PUSH;
              w_set_last = inpkt_end;
            end
          end
        end
      end
      PUSH: begin
        if (!w_fifo_full) begin
          w_push_word = 1'b1;
          w_next      = r_last ? PUSH_LIST_END : WR_WORD;
        end
      end
      PUSH_LIST_END: begin
        if (!w_fifo_full) begin
          w_push_end = 1'b1;
          w_next     = WR_WORD;
        end
      end
      DISCARD: begin
        if (w_accept && inpkt_end) w_next = PUSH_LIST_END;
      end
      default: w_next = WR_WORD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_chars               <= '0;
      r_char_count          <= '0;
      r_ranges              <= '0;
      r_range_count         <= '0;
      r_last                <= 1'b0;
      r_word_id             <= '0;
      r_err_template        <= 1'b0;
      r_err_word_list_count <= 1'b0;
    end else begin
      if (w_store_char) begin
        r_chars[int'(r_char_count)*CHAR_BITS +: CHAR_BITS] <= din[CHAR_BITS-1:0];
        r_char_count <= r_char_count + LEN_W'(1);
      end
      if (w_store_range) begin
        r_ranges[int'(r_range_count)*RW +: RW] <= {din[7], din[RMSB-1:0]};
        r_range_count <= r_range_count + RC_W'(1);
      end
      if (w_set_last) r_last <= 1'b1;
      if (w_fmt_err) begin
        r_err_template <= 1'b1;
        r_chars        <= '0;
        r_char_count   <= '0;
        r_ranges       <= '0;
        r_range_count  <= '0;
        r_last         <= 1'b0;
      end
      if (w_push_word) begin
        r_chars       <= '0;
        r_char_count  <= '0;
        r_ranges      <= '0;
        r_range_count <= '0;
        r_word_id     <= r_word_id + WORD_ID_BITS'(1);
        if (&r_word_id) r_err_word_list_count <= 1'b1;
      end
      if (w_push_end) begin
        r_word_id <= '0;
        r_last    <= 1'b0;
      end
    end
  end

  assign w_wr_data = w_push_end ? {{(ENTRY_W-1){1'b0}}, 1'b1}
                                : {r_chars, r_char_count, r_ranges, r_word_id, 1'b0};

  template_list_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_wr_en   (w_push_word || w_push_end),
    .i_wr_data (w_wr_data),
    .i_rd_en   (rd_en),
    .o_rd_data (w_rd_data),
    .o_count   (o_dbg_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (empty)
  );

  assign dout          = w_rd_data[ENTRY_W-1 -: DATA_W];
  assign word_len      = w_rd_data[ENTRY_W-DATA_W-1 -: LEN_W];
  assign range_info    = w_rd_data[WORD_ID_BITS+RANGE_W : WORD_ID_BITS+1];
  assign word_id       = w_rd_data[WORD_ID_BITS:1];
  assign word_list_end = w_rd_data[0];

  assign err_template        = r_err_template;
  assign err_word_list_count = r_err_word_list_count;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_template_list_v2.sv
// -----------------------------------------------------------------------------
// tb_template_list_v2
// Self-checking bench for template_list_v2 (WORD_ID_BITS=4, other parameters
// at their defaults). A packet-level parser derives the expected FIFO entries
// and error flags; a consumer process pops and compares entries.
// -----------------------------------------------------------------------------
module tb_template_list_v2;

  localparam int CB      = 8;
  localparam int WML     = 8;
  localparam int RM      = 8;
  localparam int OD      = 4;
  localparam int WIB     = 4;
  localparam int RMSB    = 3;                 // 1 + floor(log2(WML-1))
  localparam int RW      = RMSB + 1;
  localparam int LEN_W   = 4;                 // holds 0..8
  localparam int DATA_W  = WML * CB;
  localparam int RANGE_W = RM * RW;
  localparam int ENTRY_W = DATA_W + LEN_W + RANGE_W + WIB + 1;
  localparam logic [7:0] BAD_MASK = 8'h78;    // din[6:3]

  logic               CLK = 1'b0;
  logic               RST_N;
  logic [7:0]         din;
  logic               wr_en;
  logic               full;
  logic               inpkt_end;
  logic               is_template_list;
  logic [DATA_W-1:0]  dout;
  logic [LEN_W-1:0]   word_len;
  logic [RANGE_W-1:0] range_info;
  logic [WIB-1:0]     word_id;
  logic               word_list_end;
  logic               rd_en;
  logic               empty;
  logic               err_template;
  logic               err_word_list_count;
  logic [2:0]         dbg_state;
  logic [2:0]         dbg_fifo_count;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  template_list_v2 #(
    .CHAR_BITS    (CB),
    .WORD_MAX_LEN (WML),
    .RANGES_MAX   (RM),
    .OUT_DEPTH    (OD),
    .WORD_ID_BITS (WIB)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .din                 (din),
    .wr_en               (wr_en),
    .full                (full),
    .inpkt_end           (inpkt_end),
    .is_template_list    (is_template_list),
    .dout                (dout),
    .word_len            (word_len),
    .range_info          (range_info),
    .word_id             (word_id),
    .word_list_end       (word_list_end),
    .rd_en               (rd_en),
    .empty               (empty),
    .err_template        (err_template),
    .err_word_list_count (err_word_list_count),
    .o_dbg_state         (dbg_state),
    .o_dbg_fifo_count    (dbg_fifo_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [ENTRY_W-1:0] exp_q[$];
  logic [7:0]         pkt[$];
  int                 n_tests = 0;
  int                 n_fail  = 0;
  bit                 exp_err_t   = 1'b0;
  bit                 exp_err_cnt = 1'b0;
  int                 model_id    = 0;
  int                 bytes_acc   = 0;
  bit                 cons_en     = 1'b0;
  int                 rd_pct      = 0;
  bit                 send_done   = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Parses one complete packet (last element carries inpkt_end) into the
  // entries the receiver must emit.
  task automatic model_packet(input bit t);
    int                 i, n, len, nr, rec;
    bit                 last, ended, err;
    logic [DATA_W-1:0]  chars;
    logic [RANGE_W-1:0] rng;
    logic [7:0]         x;
    n = pkt.size();
    i = 0;
    while (i < n) begin
      chars = '0; len = 0; ended = 0; err = 0;
      while (!ended && !err) begin
        x = pkt[i]; last = (i == n - 1); i++;
        if (x != 0) begin
          chars[len*CB +: CB] = x;
          len++;
        end
        ended = (x == 0) || (len == WML);
        if (last && (t || !ended)) err = 1;
      end
      rng = '0; nr = 0;
      if (!err && t) begin
        ended = 0;
        while (!ended && !err) begin
          x = pkt[i]; last = (i == n - 1); i++;
          if ((x & BAD_MASK) != 0) err = 1;
          else begin
            if (x != 0) begin
              rec = ((x >> 7) << RMSB) + (x % (1 << RMSB));
              rng[nr*RW +: RW] = RW'(rec);
              nr++;
            end
            ended = (x == 0) || (nr == RM);
            if (last && !ended) err = 1;
          end
        end
      end
      if (err) begin
        exp_err_t = 1;
        break;
      end
      exp_q.push_back({chars, LEN_W'(len), rng, WIB'(model_id), 1'b0});
      model_id = (model_id + 1) % (1 << WIB);
      if (model_id == 0) exp_err_cnt = 1;
    end
    exp_q.push_back(ENTRY_W'(1));
    model_id = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit last, input bit t);
    int w;
    din = b; inpkt_end = last; is_template_list = t; wr_en = 1'b1;
    w = 0;
    while (full && w < 500) begin
      @(negedge CLK);
      w++;
    end
    if (full) check("accept_timeout", 1, 0);
    @(negedge CLK);
    bytes_acc++;
  endtask

  task automatic send_packet(input bit t);
    @(negedge CLK);
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], (i == pkt.size() - 1), t);
    wr_en = 1'b0; inpkt_end = 1'b0; din = 8'h00;
  endtask

  task automatic run_packet(input bit t);
    model_packet(t);
    send_packet(t);
  endtask

  task automatic set_consumer(input bit en, input int pct);
    @(posedge CLK);
    #1;
    cons_en = en; rd_pct = pct; rd_en = 1'b0;
  endtask

  task automatic check_head();
    logic [ENTRY_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_entry", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("dout",          dout,          e[ENTRY_W-1 -: DATA_W]);
    check("word_len",      word_len,      e[ENTRY_W-DATA_W-1 -: LEN_W]);
    check("range_info",    range_info,    e[WIB+RANGE_W : WIB+1]);
    check("word_id",       word_id,       e[WIB:1]);
    check("word_list_end", word_list_end, e[0]);
  endtask

  task automatic drain();
    int w;
    set_consumer(1, 60);
    w = 0;
    while ((exp_q.size() != 0 || !empty) && w < 3000) begin
      @(negedge CLK);
      w++;
    end
    check("drain_left", exp_q.size(), 0);
    check("empty_after_drain", empty, 1);
    check("err_template", err_template, exp_err_t);
    check("err_word_list_count", err_word_list_count, exp_err_cnt);
  endtask

  task automatic check_reset_state();
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_err_template", err_template, 0);
    check("rst_err_count", err_word_list_count, 0);
    check("rst_dout", dout, 0);
    check("rst_word_len", word_len, 0);
    check("rst_range_info", range_info, 0);
    check("rst_word_id", word_id, 0);
    check("rst_word_list_end", word_list_end, 0);
    check("rst_state", dbg_state, template_list_pkg::WR_WORD);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    exp_err_t = 0; exp_err_cnt = 0; model_id = 0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic gen_packet(input bit t);
    int         nw, len, nr, k, idx;
    logic [7:0] d;
    pkt.delete();
    nw = $urandom_range(1, 3);
    for (int w = 0; w < nw; w++) begin
      len = $urandom_range(0, WML);
      for (int c = 0; c < len; c++) pkt.push_back(8'($urandom_range(1, 255)));
      if (len < WML) pkt.push_back(8'h00);
      if (t) begin
        nr = $urandom_range(0, RM);
        for (int r = 0; r < nr; r++)
          pkt.push_back(8'(($urandom_range(0, 1) << 7) + $urandom_range(1, (1 << RMSB) - 1)));
        if (nr < RM) pkt.push_back(8'h00);
      end
    end
    k = $urandom_range(0, 9);
    if (k == 0 && pkt.size() > 1) begin
      idx = $urandom_range(0, pkt.size() - 2);
      while (pkt.size() > idx + 1) d = pkt.pop_back();
    end else if (k == 1) begin
      idx = $urandom_range(0, pkt.size() - 1);
      pkt[idx] = 8'h45;
    end
  endtask

  // ---------------- consumer ----------------
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge CLK);
      if (cons_en) begin
        rd_en = ($urandom_range(0, 99) < rd_pct);
        if (rd_en && !empty && RST_N) check_head();
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    RST_N = 1'b0; din = 8'h00; wr_en = 1'b0; inpkt_end = 1'b0; is_template_list = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_state();
    RST_N = 1'b1;

    // "ab",0 word list; latency of the push
    pkt = '{8'h61, 8'h62, 8'h00};
    model_packet(0);
    set_consumer(0, 0);
    send_packet(0);
    check("latency_empty_k", empty, 1);
    @(negedge CLK);
    check("latency_empty_k1", empty, 0);
    drain();

    // full-length word without terminator, then a fresh packet
    pkt = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    run_packet(0);
    pkt = '{8'h7a, 8'h00};
    run_packet(0);
    drain();

    // template list with two range records
    pkt = '{8'h78, 8'h00, 8'h81, 8'h02, 8'h00};
    model_packet(1);
    set_consumer(0, 0);
    send_packet(1);
    w = 0;
    while (empty && w < 50) begin
      @(negedge CLK);
      w++;
    end
    check("tmpl_range_direct", range_info, 32'h0000_0029);
    drain();

    // bad range byte mid-packet, then inpkt_end mid-word in a word list
    pkt = '{8'h79, 8'h00, 8'h45, 8'h01, 8'h00};
    run_packet(1);
    drain();
    pkt = '{8'h61, 8'h62};
    run_packet(0);
    drain();

    // backpressure: 6 words with no reads
    pulse_reset();
    pkt = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h63, 8'h00, 8'h64, 8'h00, 8'h65, 8'h00, 8'h66, 8'h00};
    model_packet(0);
    set_consumer(0, 0);
    bytes_acc = 0; send_done = 0;
    fork
      begin
        send_packet(0);
        send_done = 1;
      end
    join_none
    repeat (40) @(negedge CLK);
    check("stall_full", full, 1);
    check("stall_count", dbg_fifo_count, 4);
    check("stall_bytes", bytes_acc, 10);
    check("stall_state", dbg_state, template_list_pkg::PUSH);
    check_head();
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    repeat (20) @(negedge CLK);
    check("stall_bytes_after_pop", bytes_acc, 12);
    check("stall_full_after_pop", full, 1);
    check("stall_count_after_pop", dbg_fifo_count, 4);
    drain();
    check("stall_sender_done", send_done, 1);

    // 17 words with 4-bit word_id: wrap and overflow flag
    pkt.delete();
    for (int k = 0; k < 17; k++) begin
      pkt.push_back(8'(8'h61 + k));
      pkt.push_back(8'h00);
    end
    run_packet(0);
    drain();
    pulse_reset();

    // randomized packets
    set_consumer(1, 50);
    for (int p = 0; p < 60; p++) begin
      bit t;
      t = 1'($urandom_range(0, 1));
      gen_packet(t);
      run_packet(t);
    end
    drain();

    set_consumer(0, 0);
    repeat (20) @(negedge CLK);
    check("final_empty", empty, 1);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
